// File: rtl/oddr_tap_if.sv
// oddr_tap_if: tap-request handshake between a training controller (master)
// and the oddr_tap delay controller (slave). Carries the request fields plus
// the completion/status signals that answer a request.
interface oddr_tap_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [8:0] req_count;
  logic [8:0] req_value;
  logic       done;
  logic       sat;
  logic [8:0] tap_value;

  modport master (
    output req_valid, req_op, req_count, req_value,
    input  req_ready, done, sat, tap_value
  );

  modport slave (
    input  req_valid, req_op, req_count, req_value,
    output req_ready, done, sat, tap_value
  );
endinterface

// File: rtl/oddr_tap.sv
// oddr_tap: generic output DDR block with a shared output-delay tap controller.
//  - Data path: d1 is launched in the clk-high phase, d2 in the clk-low phase.
//  - Controller: Moore FSM that turns inc/dec/load requests into CE/INC/LOAD
//    strobes for an ODELAY-style primitive, holding EN_VTC low while it works.
// Optional build macro:
//  - ODDR_TAP_OE_EN : adds a per-lane output enable (q is high-Z when disabled).
// Vendor primitive mapping for TARGET "XILINX" is compiled only when the
// ODDR_TAP_UNISIM macro is defined (unisim library present); otherwise every
// target uses the fabric model below.
module oddr_tap #(
  parameter        TARGET     = "GENERIC",
  parameter int    WIDTH      = 1,
  parameter int    TAP_INIT   = 100,
  parameter int    VTC_SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
`ifdef ODDR_TAP_OE_EN
  input  logic [WIDTH-1:0] oe,
`endif
  output logic [WIDTH-1:0] q,
  oddr_tap_if.slave        req_if,
  output logic             dly_ce,
  output logic             dly_inc,
  output logic             dly_load,
  output logic             dly_en_vtc,
  output logic [8:0]       dly_cntvalue
);

  localparam logic [8:0] TAP_RST     = 9'(TAP_INIT);
  localparam logic [7:0] SETTLE_LAST = 8'(VTC_SETTLE - 1);
  localparam logic [8:0] TAP_MAX     = 9'd511;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_VTC_OFF = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_LOAD    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // ---------------------------------------------------------------------------
  // Tap controller
  // ---------------------------------------------------------------------------
  logic [2:0] state_q, state_d;
  logic       load_op_q, load_op_d;   // load or reserved op
  logic       inc_op_q, inc_op_d;     // increment (else decrement)
  logic [8:0] count_q, count_d;       // remaining steps
  logic [8:0] value_q, value_d;       // latched load value
  logic [7:0] settle_q, settle_d;     // EN_VTC settle countdown
  logic [8:0] tap_q, tap_d;
  logic       at_limit;

  // Registered Moore outputs, computed from the next state.
  logic       ready_q, ready_d;
  logic       en_vtc_q, en_vtc_d;
  logic       ce_q, ce_d;
  logic       inc_q, inc_d;
  logic       load_q, load_d;
  logic [8:0] cntvalue_q, cntvalue_d;
  logic       done_q, done_d;
  logic       sat_q, sat_d;

  // A further step in the current direction would run past the tap range.
  assign at_limit = inc_op_q ? (tap_q == TAP_MAX) : (tap_q == 9'd0);

  // Next-state, datapath and registered-output logic of the controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    load_op_d = load_op_q;
    inc_op_d  = inc_op_q;
    count_d   = count_q;
    value_d   = value_q;
    settle_d  = settle_q;
    tap_d     = tap_q;
    sat_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_if.req_valid) begin
          load_op_d = req_if.req_op[1];
          inc_op_d  = (req_if.req_op == 2'b00);
          count_d   = req_if.req_count;
          value_d   = req_if.req_value;
          settle_d  = SETTLE_LAST;
          state_d   = ST_VTC_OFF;
        end
      end
      ST_VTC_OFF: begin
        if (settle_q != 8'd0) begin
          settle_d = settle_q - 8'd1;
        end else if (load_op_q) begin
          state_d = ST_LOAD;
        end else if (count_q == 9'd0) begin
          state_d = ST_DONE;
        end else if (at_limit) begin
          state_d = ST_DONE;
          sat_d   = 1'b1;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        tap_d   = inc_op_q ? tap_q + 9'd1 : tap_q - 9'd1;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        count_d = (count_q == 9'd0) ? 9'd0 : count_q - 9'd1;
        if (count_q > 9'd1) begin
          if (at_limit) begin
            state_d = ST_DONE;
            sat_d   = 1'b1;
          end else begin
            state_d = ST_STEP;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        tap_d   = value_q;
        count_d = 9'd0;
        state_d = ST_GAP;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d    = (state_d == ST_IDLE);
    en_vtc_d   = (state_d == ST_IDLE) || (state_d == ST_DONE);
    ce_d       = (state_d == ST_STEP);
    inc_d      = ce_d && inc_op_d;
    load_d     = (state_d == ST_LOAD);
    cntvalue_d = load_d ? value_d : 9'd0;
    done_d     = (state_d == ST_DONE);
  end

  // Controller state and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      load_op_q  <= 1'b0;
      inc_op_q   <= 1'b0;
      count_q    <= 9'd0;
      value_q    <= 9'd0;
      settle_q   <= 8'd0;
      tap_q      <= TAP_RST;
      ready_q    <= 1'b1;
      en_vtc_q   <= 1'b1;
      ce_q       <= 1'b0;
      inc_q      <= 1'b0;
      load_q     <= 1'b0;
      cntvalue_q <= 9'd0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_op_q  <= load_op_d;
      inc_op_q   <= inc_op_d;
      count_q    <= count_d;
      value_q    <= value_d;
      settle_q   <= settle_d;
      tap_q      <= tap_d;
      ready_q    <= ready_d;
      en_vtc_q   <= en_vtc_d;
      ce_q       <= ce_d;
      inc_q      <= inc_d;
      load_q     <= load_d;
      cntvalue_q <= cntvalue_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign req_if.req_ready = ready_q;
  assign req_if.done      = done_q;
  assign req_if.sat       = sat_q;
  assign req_if.tap_value = tap_q;
  assign dly_ce           = ce_q;
  assign dly_inc          = inc_q;
  assign dly_load         = load_q;
  assign dly_en_vtc       = en_vtc_q;
  assign dly_cntvalue     = cntvalue_q;

  // ---------------------------------------------------------------------------
  // DDR data path
  // ---------------------------------------------------------------------------
`ifdef ODDR_TAP_UNISIM
  localparam bit USE_PRIM = (TARGET == "XILINX");
`else
  localparam bit USE_PRIM = 1'b0;
`endif

  generate
    if (USE_PRIM) begin : g_prim
`ifdef ODDR_TAP_UNISIM
      for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic oddr_q;
        logic dly_q;
        ODDRE1 #(.SRVAL(1'b0)) u_oddr (
          .Q(oddr_q), .C(clk), .D1(d1[i]), .D2(d2[i]), .SR(~rst_n)
        );
        ODELAYE3 #(
          .DELAY_FORMAT("COUNT"), .DELAY_TYPE("VAR_LOAD"), .DELAY_VALUE(TAP_INIT)
        ) u_odelay (
          .CASC_OUT(), .CNTVALUEOUT(), .DATAOUT(dly_q),
          .CASC_IN(1'b0), .CASC_RETURN(1'b0),
          .CE(ce_q), .CLK(clk), .CNTVALUEIN(cntvalue_q), .EN_VTC(en_vtc_q),
          .INC(inc_q), .LOAD(load_q), .ODATAIN(oddr_q), .RST(~rst_n)
        );
`ifdef ODDR_TAP_OE_EN
        // Tristate control goes through its own ODDRE1 so it shares d1's latency.
        logic tri_q;
        ODDRE1 #(.SRVAL(1'b1)) u_oddr_t (
          .Q(tri_q), .C(clk), .D1(~oe[i]), .D2(~oe[i]), .SR(~rst_n)
        );
        OBUFT u_obuft (.O(q[i]), .I(dly_q), .T(tri_q));
`else
        assign q[i] = dly_q;
`endif
      end
`endif
    end else begin : g_fabric
      logic [WIDTH-1:0] d1_q;
      logic [WIDTH-1:0] d2_q;
      logic [WIDTH-1:0] d2_neg_q;
      logic [WIDTH-1:0] lane_q;

      // Capture both SDR words on the rising edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          d1_q <= '0;
          d2_q <= '0;
        end else begin
          d1_q <= d1;
          d2_q <= d2;
        end
      end

      // Retime d2 onto the falling edge so it is stable for the whole low phase.
      always_ff @(negedge clk) begin
        if (!rst_n) d2_neg_q <= '0;
        else        d2_neg_q <= d2_q;
      end

      assign lane_q = clk ? d1_q : d2_neg_q;

`ifdef ODDR_TAP_OE_EN
      logic [WIDTH-1:0] oe_q;

      // Output enable follows the same posedge capture as d1.
      always_ff @(posedge clk) begin
        if (!rst_n) oe_q <= '0;
        else        oe_q <= oe;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_oe
        assign q[i] = oe_q[i] ? lane_q[i] : 1'bz;
      end
`else
      assign q = lane_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_oddr_tap.sv
// tb_oddr_tap: scoreboard bench for oddr_tap. Drivers push expected results
// into queues; independent monitors pop and compare when the DUT responds.
module tb_oddr_tap;
  localparam int WIDTH      = 4;
  localparam int TAP_INIT   = 100;
  localparam int VTC_SETTLE = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] d1    = '0;
  logic [WIDTH-1:0] d2    = '0;
  logic [WIDTH-1:0] oe_v  = '1;
  wire  [WIDTH-1:0] q;
  logic             dly_ce, dly_inc, dly_load, dly_en_vtc;
  logic [8:0]       dly_cntvalue;

  oddr_tap_if req_if ();

  oddr_tap #(
    .TARGET("GENERIC"), .WIDTH(WIDTH), .TAP_INIT(TAP_INIT), .VTC_SETTLE(VTC_SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d1(d1), .d2(d2),
`ifdef ODDR_TAP_OE_EN
    .oe(oe_v),
`endif
    .q(q), .req_if(req_if),
    .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_load(dly_load),
    .dly_en_vtc(dly_en_vtc), .dly_cntvalue(dly_cntvalue)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- data path
  typedef struct {
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] oe;
  } dat_t;

  dat_t dq[$];
  bit   run_data = 1'b0;

  function automatic logic [WIDTH-1:0] pin(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] en);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = en[i] ? v[i] : 1'bz;
    return r;
  endfunction

  // Each entry is pushed when driven; the word is captured at the next posedge,
  // so the oldest entry is on the pin once a newer one has been queued.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst_n) dq.delete();
      else if (dq.size() >= 2) check("q_high_phase", 32'(q), 32'(pin(dq[0].d1, dq[0].oe)));
      @(negedge clk); #2;
      if (!rst_n) dq.delete();
      else if (dq.size() >= 2) begin
        check("q_low_phase", 32'(q), 32'(pin(dq[0].d2, dq[0].oe)));
        void'(dq.pop_front());
      end
    end
  end

  // ------------------------------------------------------------ tap controller
  typedef struct {
    int         t;
    int         done_at;
    int         n_ce;
    bit         inc;
    bit         is_load;
    logic [8:0] load_val;
    logic [8:0] tap;
    bit         sat;
  } op_exp_t;

  op_exp_t opq[$];
  int      model_tap = TAP_INIT;

  // Reference: steps actually issued are limited by the headroom to 511 / 0.
  function automatic op_exp_t predict(input int t, input logic [1:0] op, input int cnt, input int val);
    op_exp_t e;
    int room, m;
    e.t = t; e.is_load = op[1]; e.inc = (op == 2'b00);
    e.load_val = 9'(val); e.sat = 1'b0; e.n_ce = 0;
    if (op[1]) begin
      e.tap     = 9'(val);
      e.done_at = t + VTC_SETTLE + 3;
    end else begin
      room      = (op == 2'b00) ? 511 - model_tap : model_tap;
      m         = (cnt < room) ? cnt : room;
      e.sat     = (m < cnt);
      e.n_ce    = m;
      e.tap     = 9'((op == 2'b00) ? model_tap + m : model_tap - m);
      e.done_at = t + VTC_SETTLE + 2 * m + 1;
    end
    return e;
  endfunction

  int ce_seen = 0;
  int ld_seen = 0;

  initial begin
    forever begin
      op_exp_t e;
      bit busy, vtc_low;
      @(negedge clk);
      if (!rst_n) begin
        ce_seen = 0;
        ld_seen = 0;
      end else if (opq.size() == 0) begin
        check("idle_done", 32'(req_if.done), 0);
        check("idle_ready", 32'(req_if.req_ready), 1);
        check("idle_en_vtc", 32'(dly_en_vtc), 1);
        check("idle_ce", 32'(dly_ce), 0);
        check("idle_load", 32'(dly_load), 0);
      end else begin
        e       = opq[0];
        busy    = (cyc > e.t) && (cyc <= e.done_at);
        vtc_low = (cyc > e.t) && (cyc < e.done_at);
        check("ready", 32'(req_if.req_ready), 32'(!busy));
        check("en_vtc", 32'(dly_en_vtc), 32'(!vtc_low));
        if (dly_ce) begin
          check("ce_cycle", cyc, e.t + VTC_SETTLE + 1 + 2 * ce_seen);
          check("ce_dir", 32'(dly_inc), 32'(e.inc));
          ce_seen++;
        end
        if (dly_load) begin
          check("load_cycle", cyc, e.t + VTC_SETTLE + 1);
          check("load_value", 32'(dly_cntvalue), 32'(e.load_val));
          ld_seen++;
        end
        if (req_if.done) begin
          check("done_cycle", cyc, e.done_at);
          check("tap_value", 32'(req_if.tap_value), 32'(e.tap));
          check("sat", 32'(req_if.sat), 32'(e.sat));
          check("ce_count", ce_seen, e.n_ce);
          check("load_count", ld_seen, 32'(e.is_load));
          void'(opq.pop_front());
          ce_seen = 0;
          ld_seen = 0;
        end else if (cyc > e.done_at) begin
          check("done_missing", 0, 1);
          void'(opq.pop_front());
          ce_seen = 0;
          ld_seen = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (opq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (opq.size() != 0) begin
      check("done_timeout", opq.size(), 0);
      opq.delete();
    end
    @(negedge clk);
  endtask

  // Issue one request; after acceptance keep valid high with junk fields for a
  // few cycles to show busy-time requests are ignored.
  task automatic issue(input logic [1:0] op, input int cnt, input int val, input bit wait_done);
    op_exp_t e;
    bit acc = 1'b0;
    @(posedge clk); #1;
    req_if.req_valid = 1'b1;
    req_if.req_op    = op;
    req_if.req_count = 9'(cnt);
    req_if.req_value = 9'(val);
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (req_if.req_ready) begin
        acc = 1'b1;
        e   = predict(cyc, op, cnt, val);
        opq.push_back(e);
        model_tap = e.tap;
      end
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
      req_if.req_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_if.req_op    = 2'($urandom);
      req_if.req_count = 9'($urandom);
      req_if.req_value = 9'($urandom);
    end
    req_if.req_valid = 1'b0;
    if (wait_done) wait_idle();
  endtask

  function automatic int pick_value();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 511;
      2:       return $urandom_range(1, 6);
      3:       return $urandom_range(505, 510);
      default: return $urandom_range(0, 511);
    endcase
  endfunction

  // ------------------------------------------------------------------ stimulus
  initial begin
    logic [WIDTH-1:0] q_rst;
    bit seen;
    req_if.req_valid = 1'b0;
    req_if.req_op    = 2'b00;
    req_if.req_count = 9'd0;
    req_if.req_value = 9'd0;
`ifdef ODDR_TAP_OE_EN
    oe_v  = '0;
    q_rst = '0;
    q_rst = pin(q_rst, '0);
`else
    q_rst = '0;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check("rst_q_low", 32'(q), 32'(q_rst));
    check("rst_tap", 32'(req_if.tap_value), TAP_INIT);
    check("rst_ready", 32'(req_if.req_ready), 1);
    check("rst_en_vtc", 32'(dly_en_vtc), 1);
    check("rst_done", 32'(req_if.done), 0);
    @(posedge clk); #2;
    check("rst_q_high", 32'(q), 32'(q_rst));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Data driver: held pattern, swapped pattern, then random words.
    run_data = 1'b1;
    fork
      begin
        int k = 0;
        while (run_data) begin
          @(posedge clk); #1;
          if (k < 4)      begin d1 = '1; d2 = '0; end
          else if (k < 8) begin d1 = '0; d2 = '1; end
          else            begin d1 = WIDTH'($urandom); d2 = WIDTH'($urandom); end
`ifdef ODDR_TAP_OE_EN
          oe_v = (k < 2) ? '0 : ((k < 8) ? '1 : WIDTH'($urandom));
`endif
          dq.push_back('{d1: d1, d2: d2, oe: oe_v});
          k++;
        end
      end
    join_none

    // Directed tap operations.
    issue(2'b00, 3, 0, 1);            // inc 3 -> 103
    issue(2'b10, 0, 500, 1);          // load 500
    issue(2'b00, 20, 0, 1);           // 11 steps, saturates at 511
    issue(2'b01, 0, 0, 1);            // count 0
    issue(2'b10, 0, 0, 1);            // load 0
    issue(2'b01, 5, 0, 1);            // dec at 0 -> immediate sat
    issue(2'b11, 0, 300, 1);          // reserved op acts as load
    issue(2'b00, 0, 0, 1);            // inc count 0
    issue(2'b01, 7, 0, 1);            // dec 7 -> 293

    // Randomised operations.
    for (int i = 0; i < 25; i++)
      issue(2'($urandom_range(0, 3)), $urandom_range(0, 14), pick_value(), 1);

    // Reset in the middle of a 10-step decrement.
    issue(2'b10, 0, 200, 1);
    issue(2'b01, 10, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dly_ce) seen = 1'b1;
    end
    check("midop_ce_seen", 32'(seen), 1);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    check("midop_rst_tap", 32'(req_if.tap_value), TAP_INIT);
    check("midop_rst_en_vtc", 32'(dly_en_vtc), 1);
    check("midop_rst_done", 32'(req_if.done), 0);
    check("midop_rst_ready", 32'(req_if.req_ready), 1);
    @(negedge clk);
    opq.delete();
    model_tap = TAP_INIT;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(2'b00, 2, 0, 1);            // 100 -> 102

    run_data = 1'b0;
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
